// File: rtl/lsb_reducer_pkg.sv
// Shared defaults and controller state encoding for the lsb_reducer stage.
package lsb_reducer_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 4;
    localparam int unsigned DEFAULT_STEP_W = 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REDUCE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

endpackage

// File: rtl/lsb_reducer_lsb_clear.sv
// Combinational lowest-set-bit clear: r & (r - 1), wrapping modulo 2^WIDTH.
module lsb_clear #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_clr
);

    assign r_clr = r & (r - WIDTH'(1));

endmodule

// File: rtl/lsb_reducer.sv
// Loads an operand on start, then strips its lowest set bit each cycle until the
// downstream one-hot checker reports a single bit left.
module lsb_reducer
    import lsb_reducer_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STEP_W = DEFAULT_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  din,
    input  logic              is_finished,
    output logic              ready,
    output logic              busy,
    output logic [WIDTH-1:0]  a_out,
    output logic [STEP_W-1:0] steps,
    output logic              done,
    output logic              zero_err
);

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [WIDTH-1:0]  a_clr;

    lsb_clear #(
        .WIDTH (WIDTH)
    ) u_lsb_clear (
        .r     (a_q),
        .r_clr (a_clr)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        steps_d = steps_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = din;
                    steps_d = '0;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                // Zero check outranks is_finished so a 0 operand can never report done.
                if (a_q == '0) begin
                    state_d = S_ERR;
                end else if (is_finished) begin
                    state_d = S_DONE;
                end else begin
                    a_d     = a_clr;
                    steps_d = steps_q + STEP_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            steps_q <= steps_d;
        end
    end

    always_comb begin
        ready    = (state_q == S_IDLE);
        busy     = (state_q == S_REDUCE);
        done     = (state_q == S_DONE);
        zero_err = (state_q == S_ERR);
        a_out    = a_q;
        steps    = steps_q;
    end

endmodule

// File: tb/tb_lsb_reducer.sv
// Directed bench for lsb_reducer with a behavioural one-hot checker in the feedback path.
module tb_lsb_reducer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] din;
    logic       is_finished;
    logic       ready;
    logic       busy;
    logic [3:0] a_out;
    logic [2:0] steps;
    logic       done;
    logic       zero_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stand-in for the downstream check block.
    assign is_finished = (a_out != 4'd0) && ((a_out & (a_out - 4'd1)) == 4'd0);

    lsb_reducer #(
        .WIDTH  (4),
        .STEP_W (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .din         (din),
        .is_finished (is_finished),
        .ready       (ready),
        .busy        (busy),
        .a_out       (a_out),
        .steps       (steps),
        .done        (done),
        .zero_err    (zero_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [3:0] val);
        din   = val;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = 4'd0;
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_a", 32'(a_out), 32'd0);
        chk("rst_steps", 32'(steps), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_zerr", 32'(zero_err), 32'd0);
        rst = 1'b0;
        tick();

        // 1011 -> 1010 -> 1000, done in cycle 3
        accept(4'b1011);
        chk("t1_c0_busy", 32'(busy), 32'd1);
        chk("t1_c0_ready", 32'(ready), 32'd0);
        chk("t1_c0_a", 32'(a_out), 32'hb);
        tick();
        chk("t1_c1_a", 32'(a_out), 32'ha);
        chk("t1_c1_done", 32'(done), 32'd0);
        tick();
        chk("t1_c2_a", 32'(a_out), 32'h8);
        chk("t1_c2_done", 32'(done), 32'd0);
        tick();
        chk("t1_c3_done", 32'(done), 32'd1);
        chk("t1_c3_busy", 32'(busy), 32'd0);
        chk("t1_c3_ready", 32'(ready), 32'd0);
        chk("t1_c3_a", 32'(a_out), 32'h8);
        chk("t1_c3_steps", 32'(steps), 32'd2);
        tick();
        chk("t1_c4_done", 32'(done), 32'd0);
        chk("t1_c4_ready", 32'(ready), 32'd1);
        chk("t1_c4_hold_a", 32'(a_out), 32'h8);
        chk("t1_c4_hold_steps", 32'(steps), 32'd2);

        // 0100: already one-hot
        accept(4'b0100);
        chk("t2_c0_done", 32'(done), 32'd0);
        tick();
        chk("t2_c1_done", 32'(done), 32'd1);
        chk("t2_c1_a", 32'(a_out), 32'h4);
        chk("t2_c1_steps", 32'(steps), 32'd0);
        tick();

        // 1111 -> 1110 -> 1100 -> 1000, done in cycle 4
        accept(4'b1111);
        tick();
        chk("t3_c1_a", 32'(a_out), 32'he);
        tick();
        chk("t3_c2_a", 32'(a_out), 32'hc);
        tick();
        chk("t3_c3_a", 32'(a_out), 32'h8);
        chk("t3_c3_done", 32'(done), 32'd0);
        tick();
        chk("t3_c4_done", 32'(done), 32'd1);
        chk("t3_c4_steps", 32'(steps), 32'd3);
        chk("t3_c4_a", 32'(a_out), 32'h8);
        tick();

        // zero operand
        accept(4'b0000);
        tick();
        chk("t4_c1_zerr", 32'(zero_err), 32'd1);
        chk("t4_c1_done", 32'(done), 32'd0);
        chk("t4_c1_a", 32'(a_out), 32'd0);
        chk("t4_c1_steps", 32'(steps), 32'd0);
        tick();
        chk("t4_c2_ready", 32'(ready), 32'd1);
        chk("t4_c2_zerr", 32'(zero_err), 32'd0);
        chk("t4_c2_done", 32'(done), 32'd0);

        // start while busy is ignored, then held start gives back-to-back ops
        accept(4'b1111);
        tick();
        tick();
        din   = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_c3_a", 32'(a_out), 32'h8);
        chk("t5_c3_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_c4_done", 32'(done), 32'd1);
        chk("t5_c4_a", 32'(a_out), 32'h8);
        chk("t5_c4_steps", 32'(steps), 32'd3);
        din   = 4'b0011;
        start = 1'b1;
        tick();
        chk("t5_idle_ready", 32'(ready), 32'd1);
        tick();
        chk("t5_re_c0_a", 32'(a_out), 32'h3);
        chk("t5_re_c0_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_re_c1_a", 32'(a_out), 32'h2);
        chk("t5_re_c1_done", 32'(done), 32'd0);
        tick();
        chk("t5_re_c2_done", 32'(done), 32'd1);
        chk("t5_re_c2_a", 32'(a_out), 32'h2);
        chk("t5_re_c2_steps", 32'(steps), 32'd1);
        start = 1'b0;
        tick();
        chk("t5_end_ready", 32'(ready), 32'd1);

        // reset mid-operation
        accept(4'b1111);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_a", 32'(a_out), 32'd0);
        chk("t6_steps", 32'(steps), 32'd0);
        chk("t6_ready", 32'(ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_done", 32'(done), 32'd0);
            chk("t6_stay_idle", 32'(ready), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
